// File: rtl/mat_pkg.sv
// -----------------------------------------------------------------------------
// mat_pkg
// Shared definitions for the systolic-array weight/activation feeder.
//   WORD_W_DEFAULT : default lane word width (IEEE-754 single bit pattern)
//   N_DEFAULT      : default array dimension (lanes)
//   feeder_state_e : feeder FSM state encoding
// -----------------------------------------------------------------------------
package mat_pkg;

   localparam int unsigned WORD_W_DEFAULT = 32;
   localparam int unsigned N_DEFAULT      = 4;

   typedef enum logic [1:0] {
      W_FILL = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } feeder_state_e;

endpackage : mat_pkg

// File: rtl/mat_feeder_if.sv
// -----------------------------------------------------------------------------
// mat_feeder_if
// Groups the feeder's handshake and MatUnit-facing signals.
//   w_valid/w_ready/w_data : weight-row handshake, lane i at [i*WORD_W +: WORD_W]
//   x_valid/x_ready/x_data : activation-vector handshake, same lane packing
//   mat_load_weight        : MatUnit load_weight
//   mat_weight_progress    : MatUnit weight_progress, $clog2(2N) bits
//   mat_data_in            : skewed lane words to MatUnit data_in
//   busy                   : high whenever the feeder is not filling weights
// Modports: master = producer/consumer side, slave = feeder side.
// -----------------------------------------------------------------------------
interface mat_feeder_if
   import mat_pkg::*;
#(
   parameter int unsigned N      = N_DEFAULT,
   parameter int unsigned WORD_W = WORD_W_DEFAULT
);
   localparam int unsigned DW = N * WORD_W;
   localparam int unsigned PW = $clog2(2 * N);

   logic          w_valid;
   logic          w_ready;
   logic [DW-1:0] w_data;
   logic          x_valid;
   logic          x_ready;
   logic [DW-1:0] x_data;
   logic          mat_load_weight;
   logic [PW-1:0] mat_weight_progress;
   logic [DW-1:0] mat_data_in;
   logic          busy;

   modport master (
      output w_valid, w_data, x_valid, x_data,
      input  w_ready, x_ready, mat_load_weight, mat_weight_progress,
             mat_data_in, busy
   );

   modport slave (
      input  w_valid, w_data, x_valid, x_data,
      output w_ready, x_ready, mat_load_weight, mat_weight_progress,
             mat_data_in, busy
   );

endinterface : mat_feeder_if

// File: rtl/mat_skew_line.sv
// -----------------------------------------------------------------------------
// mat_skew_line
// Per-lane delay line of DEPTH registers (DEPTH = 0 is a straight wire).
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears every stage
//   d_i     : lane word in
//   q_o     : lane word delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module mat_skew_line #(
   parameter int unsigned DEPTH = 0,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst;
         assign unused_clk_rst = clock ^ reset_n;
         assign q_o = d_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] pipe_q [DEPTH];

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               for (int unsigned k = 0; k < DEPTH; k++) begin
                  pipe_q[k] <= '0;
               end
            end else begin
               pipe_q[0] <= d_i;
               for (int unsigned k = 1; k < DEPTH; k++) begin
                  pipe_q[k] <= pipe_q[k-1];
               end
            end
         end

         assign q_o = pipe_q[DEPTH-1];
      end
   endgenerate

endmodule : mat_skew_line

// File: rtl/mat_feeder.sv
// -----------------------------------------------------------------------------
// mat_feeder
// Buffers N weight rows, loads them diagonally into an N x N systolic MatUnit
// over 2N cycles, then streams skewed activation vectors until a new weight
// row is offered, drains the skew line and returns to weight filling.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mat_feeder_if slave modport (handshakes + MatUnit outputs)
// -----------------------------------------------------------------------------
module mat_feeder
   import mat_pkg::*;
#(
   parameter int unsigned N      = N_DEFAULT,
   parameter int unsigned WORD_W = WORD_W_DEFAULT
) (
   input  logic         clock,
   input  logic         reset_n,
   mat_feeder_if.slave  bus
);

   localparam int unsigned DW = N * WORD_W;
   localparam int unsigned PW = $clog2(2 * N);
   localparam int unsigned FW = $clog2(N);

   feeder_state_e state_q, state_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [PW-1:0] cnt_q, cnt_d;      // LOAD progress, reused as DRAIN counter
   logic [DW-1:0] stage_q, stage_d;  // vector entering the skew lines
   logic [DW-1:0] wbuf_q [N];
   logic          w_fire;
   logic [DW-1:0] skew_out;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= W_FILL;
         fill_q  <= '0;
         cnt_q   <= '0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < N; k++) begin
            wbuf_q[k] <= '0;
         end
      end else if (w_fire) begin
         wbuf_q[fill_q] <= bus.w_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and stage selection.
   // The stage register sits in front of every skew line, so the value for
   // LOAD cycle p is staged one edge early: row 0 on the final fill handshake,
   // row p+1 during LOAD cycle p. Lane i therefore sees row (p-i) at cycle p,
   // and a vector accepted at edge t reaches lane i in cycle t+1+i. One side
   // effect: the last accepted vector's lane N-1 word is presented during the
   // first W_FILL cycle after DRAIN.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      stage_d = '0;
      w_fire  = 1'b0;

      unique case (state_q)
         W_FILL: begin
            if (bus.w_valid) begin
               w_fire = 1'b1;
               if (fill_q == FW'(N - 1)) begin
                  fill_d  = '0;
                  stage_d = wbuf_q[0];
                  state_d = LOAD;
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
         end

         LOAD: begin
            for (int unsigned k = 1; k < N; k++) begin
               if (cnt_q == PW'(k - 1)) begin
                  stage_d = wbuf_q[k];
               end
            end
            if (cnt_q == PW'(2 * N - 1)) begin
               cnt_d   = '0;
               state_d = STREAM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STREAM: begin
            if (bus.x_valid) begin
               stage_d = bus.x_data;
            end
            if (bus.w_valid) begin
               state_d = DRAIN;
            end
         end

         DRAIN: begin
            if (cnt_q == PW'(N - 2)) begin
               cnt_d   = '0;
               state_d = W_FILL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = W_FILL;
            fill_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Skew lines: lane i delayed by i cycles
   // ---------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < N; i++) begin : g_lane
         mat_skew_line #(
            .DEPTH (i),
            .WIDTH (WORD_W)
         ) u_skew (
            .clock   (clock),
            .reset_n (reset_n),
            .d_i     (stage_q[i*WORD_W +: WORD_W]),
            .q_o     (skew_out[i*WORD_W +: WORD_W])
         );
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Outputs (all derived from registers; ready lines masked during reset)
   // ---------------------------------------------------------------------------
   assign bus.w_ready             = reset_n && (state_q == W_FILL);
   assign bus.x_ready             = reset_n && (state_q == STREAM);
   assign bus.busy                = (state_q != W_FILL);
   assign bus.mat_load_weight     = (state_q == LOAD);
   assign bus.mat_weight_progress = (state_q == LOAD) ? cnt_q : '0;
   assign bus.mat_data_in         = skew_out;

endmodule : mat_feeder

// File: tb/tb_mat_feeder.sv
// -----------------------------------------------------------------------------
// tb_mat_feeder
// Self-checking bench for mat_feeder with N=4, WORD_W=32.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Streamed lane words are checked against per-lane expected
// queues filled as vectors are injected.
// -----------------------------------------------------------------------------
module tb_mat_feeder;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int DW = N * W;
   localparam int PW = $clog2(2 * N);

   localparam logic [W-1:0] F1 = 32'h3F80_0000;  // 1.0
   localparam logic [W-1:0] F2 = 32'h4000_0000;  // 2.0
   localparam logic [W-1:0] F5 = 32'h40A0_0000;  // 5.0

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   always #5 clock = ~clock;

   mat_feeder_if #(.N(N), .WORD_W(W)) bus ();

   mat_feeder #(.N(N), .WORD_W(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] rows [N];
   logic [W-1:0]  lane_q [N][$];

   typedef struct {
      logic wv;
      logic exp_wr;
      logic exp_busy;
   } fvec_t;

   typedef struct {
      logic          xv;
      logic          wv;
      logic [DW-1:0] xd;
   } svec_t;

   function automatic logic [DW-1:0] vec4(input logic [W-1:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic ctrl(input string nm, input logic wr, input logic xr, input logic bz,
                       input logic ld, input logic [PW-1:0] pg);
      chk({nm, "_w_ready"}, DW'(bus.w_ready), DW'(wr));
      chk({nm, "_x_ready"}, DW'(bus.x_ready), DW'(xr));
      chk({nm, "_busy"}, DW'(bus.busy), DW'(bz));
      chk({nm, "_load_weight"}, DW'(bus.mat_load_weight), DW'(ld));
      chk({nm, "_progress"}, DW'(bus.mat_weight_progress), DW'(pg));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic wv, input logic [DW-1:0] wd,
                        input logic xv, input logic [DW-1:0] xd);
      bus.w_valid = wv;
      bus.w_data  = wd;
      bus.x_valid = xv;
      bus.x_data  = xd;
   endtask

   // Diagonal weight pattern: lane i carries row (p-i) element i, else zero.
   function automatic logic [DW-1:0] load_exp(input int p);
      logic [DW-1:0] e;
      logic [DW-1:0] r;
      e = '0;
      for (int i = 0; i < N; i++) begin
         if ((p - i) >= 0 && (p - i) < N) begin
            r = rows[p - i];
            e[i*W +: W] = r[i*W +: W];
         end
      end
      return e;
   endfunction

   task automatic load_cycle(input int p);
      ctrl($sformatf("load_p%0d", p), 1'b0, 1'b0, 1'b1, 1'b1, PW'(p));
      chk($sformatf("load_p%0d_data", p), bus.mat_data_in, load_exp(p));
   endtask

   // Lane i needs i+1 leading zeros: one for the stage register, i for its skew.
   task automatic sb_reset();
      for (int i = 0; i < N; i++) begin
         lane_q[i].delete();
         for (int k = 0; k <= i; k++) lane_q[i].push_back('0);
      end
   endtask

   task automatic sb_push(input logic [DW-1:0] v);
      for (int i = 0; i < N; i++) lane_q[i].push_back(v[i*W +: W]);
   endtask

   task automatic sb_check(input string nm);
      logic [DW-1:0] e;
      e = '0;
      for (int i = 0; i < N; i++) begin
         if (lane_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_underflow: lane %0d has no expected word, expected a queued word", nm, i);
         end else begin
            e[i*W +: W] = lane_q[i].pop_front();
         end
      end
      chk(nm, bus.mat_data_in, e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      fvec_t ftab [6];
      svec_t stab [15];
      int    hs;

      ftab[0] = '{1'b1, 1'b1, 1'b0};
      ftab[1] = '{1'b0, 1'b1, 1'b0};
      ftab[2] = '{1'b1, 1'b1, 1'b0};
      ftab[3] = '{1'b0, 1'b1, 1'b0};
      ftab[4] = '{1'b1, 1'b1, 1'b0};
      ftab[5] = '{1'b1, 1'b1, 1'b0};

      stab[0]  = '{1'b1, 1'b0, vec4(F5, F5, F5, F5)};
      stab[1]  = '{1'b1, 1'b0, vec4(F5, F5, F5, F5)};
      stab[2]  = '{1'b1, 1'b0, vec4(F5, F5, F5, F5)};
      stab[3]  = '{1'b1, 1'b0, vec4(F5, F5, F5, F5)};
      stab[4]  = '{1'b0, 1'b0, vec4(F5, F2, F5, F2)};
      stab[5]  = '{1'b0, 1'b0, vec4(F5, F2, F5, F2)};
      stab[6]  = '{1'b0, 1'b0, vec4(F5, F2, F5, F2)};
      stab[7]  = '{1'b1, 1'b0, vec4(F1, '0, F1, '0)};
      stab[8]  = '{1'b0, 1'b0, vec4(F5, F5, F5, F5)};
      stab[9]  = '{1'b1, 1'b0, vec4('0, F2, '0, F1)};
      stab[10] = '{1'b0, 1'b0, vec4(F2, F2, F2, F2)};
      stab[11] = '{1'b1, 1'b0, vec4(32'h1, 32'h2, 32'h3, 32'h4)};
      stab[12] = '{1'b1, 1'b0, vec4(32'h5, 32'h6, 32'h7, 32'h8)};
      stab[13] = '{1'b0, 1'b0, vec4(32'h9, 32'h9, 32'h9, 32'h9)};
      stab[14] = '{1'b1, 1'b1, vec4(32'h0A0A_0001, 32'h0B0B_0002, 32'h0C0C_0003, 32'h0D0D_0004)};

      // Reset
      drive(1'b0, '0, 1'b0, '0);
      #1 reset_n = 1'b0;
      @(negedge clock);
      ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("reset_data", bus.mat_data_in, '0);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // Fill with rows of 1.0 on consecutive handshakes
      for (int r = 0; r < N; r++) rows[r] = vec4(F1, F1, F1, F1);
      for (int k = 0; k < N; k++) begin
         drive(1'b1, rows[k], 1'b0, '0);
         @(negedge clock);
         ctrl("fill1", 1'b1, 1'b0, 1'b0, 1'b0, '0);
         chk("fill1_data", bus.mat_data_in, '0);
         step();
      end
      drive(1'b0, '0, 1'b0, '0);

      // Full diagonal load
      for (int p = 0; p < 2 * N; p++) begin
         @(negedge clock);
         load_cycle(p);
         step();
      end

      // Stream with bursts, bubbles and the reload request on the last entry
      sb_reset();
      for (int e = 0; e < 15; e++) begin
         drive(stab[e].wv, '0, stab[e].xv, stab[e].xd);
         @(negedge clock);
         ctrl("stream", 1'b0, 1'b1, 1'b1, 1'b0, '0);
         sb_check("stream_data");
         step();
         sb_push(stab[e].xv ? stab[e].xd : '0);
      end

      // Drain: x_valid held high with junk, nothing may be accepted
      for (int d = 0; d < N - 1; d++) begin
         drive(1'b0, '0, 1'b1, vec4(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004));
         @(negedge clock);
         ctrl("drain", 1'b0, 1'b0, 1'b1, 1'b0, '0);
         sb_check("drain_data");
         step();
         sb_push('0);
      end

      // Back in W_FILL: last vector's lane 3 word leaves, then all zero
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, '0, 1'b0, '0);
         @(negedge clock);
         ctrl("refill", 1'b1, 1'b0, 1'b0, 1'b0, '0);
         sb_check("refill_data");
         if (k == 1) chk("wfill_zero", bus.mat_data_in, '0);
         step();
         sb_push('0);
      end

      // Second fill with distinct rows and a toggling w_valid
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) rows[k][i*W +: W] = 32'h4110_0000 + W'(k * 16 + i);
      end
      hs = 0;
      for (int e = 0; e < 6; e++) begin
         drive(ftab[e].wv, rows[hs], 1'b0, '0);
         @(negedge clock);
         chk($sformatf("fill2_e%0d_w_ready", e), DW'(bus.w_ready), DW'(ftab[e].exp_wr));
         chk($sformatf("fill2_e%0d_busy", e), DW'(bus.busy), DW'(ftab[e].exp_busy));
         chk($sformatf("fill2_e%0d_load", e), DW'(bus.mat_load_weight), '0);
         chk($sformatf("fill2_e%0d_data", e), bus.mat_data_in, '0);
         step();
         if (ftab[e].wv) hs++;
      end
      drive(1'b0, '0, 1'b0, '0);

      // Load up to p=5, then asynchronous reset in the middle of the cycle
      for (int p = 0; p <= 5; p++) begin
         @(negedge clock);
         load_cycle(p);
         if (p < 5) step();
      end
      #2 reset_n = 1'b0;
      #1;
      ctrl("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("async_reset_data", bus.mat_data_in, '0);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // Four fresh rows are needed before LOAD starts again
      for (int r = 0; r < N; r++) rows[r] = vec4(F2, F2, F2, F2);
      for (int k = 0; k < N; k++) begin
         drive(1'b1, rows[k], 1'b0, '0);
         @(negedge clock);
         ctrl("fill3", 1'b1, 1'b0, 1'b0, 1'b0, '0);
         chk("fill3_data", bus.mat_data_in, '0);
         step();
      end
      drive(1'b0, '0, 1'b0, '0);
      for (int p = 0; p < 2; p++) begin
         @(negedge clock);
         load_cycle(p);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mat_feeder
